// File: rtl/inst_fetch.sv
// Instruction-fetch sequencer: issues word fetches over req/ack, presents the
// instruction to decode over valid/ready, and drives the PC register update.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        pc_ena,
    output logic [31:0] pc_next
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [31:0] imem_addr_reg;
    logic [31:0] inst_reg;
    logic [31:0] inst_pc_reg;
    logic [31:0] target_reg, target_next;
    logic [31:0] pc_next_reg, pc_next_comb;
    logic        pc_ena_comb;
    logic        capture_inst;
    logic        start_req;
    logic [31:0] redirect_aligned;
    logic        unused_low_bits;

    assign redirect_aligned = {redirect_target[31:2], 2'b00};
    // Low address bits never reach a word fetch.
    assign unused_low_bits  = ^{pc[1:0], redirect_target[1:0]};

    always_comb begin
        state_next   = state_reg;
        target_next  = target_reg;
        pc_ena_comb  = 1'b0;
        pc_next_comb = pc_next_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (redirect && imem_ack) begin
                    // Data that lands with a redirect is stale: drop it and refetch at once.
                    pc_ena_comb  = 1'b1;
                    pc_next_comb = redirect_aligned;
                    state_next   = ST_REQ;
                end else if (redirect) begin
                    target_next = redirect_aligned;
                    state_next  = ST_FLUSH;
                end else if (imem_ack) begin
                    state_next = ST_VALID;
                end
            end
            ST_VALID: begin
                if (redirect) begin
                    pc_ena_comb  = 1'b1;
                    pc_next_comb = redirect_aligned;
                    state_next   = ST_REQ;
                end else if (inst_ready) begin
                    pc_ena_comb  = 1'b1;
                    pc_next_comb = inst_pc_reg + 32'd4;
                    state_next   = ST_REQ;
                end
            end
            default: begin
                if (imem_ack) begin
                    pc_ena_comb  = 1'b1;
                    pc_next_comb = redirect ? redirect_aligned : target_reg;
                    state_next   = ST_REQ;
                end else if (redirect) begin
                    target_next = redirect_aligned;
                end
            end
        endcase
    end

    assign capture_inst = (state_reg == ST_REQ) && imem_ack && !redirect;
    // The PC register updates on the falling edge, so pc is already current here.
    assign start_req    = (state_next == ST_REQ) && ((state_reg != ST_REQ) || pc_ena_comb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            imem_addr_reg <= RESET_PC;
            inst_reg      <= 32'd0;
            inst_pc_reg   <= RESET_PC;
            target_reg    <= RESET_PC;
            pc_next_reg   <= RESET_PC;
        end else begin
            state_reg   <= state_next;
            target_reg  <= target_next;
            pc_next_reg <= pc_next_comb;
            if (start_req) begin
                imem_addr_reg <= {pc[31:2], 2'b00};
            end
            if (capture_inst) begin
                inst_reg    <= imem_rdata;
                inst_pc_reg <= imem_addr_reg;
            end
        end
    end

    assign imem_req   = (state_reg == ST_REQ) || (state_reg == ST_FLUSH);
    assign imem_addr  = imem_addr_reg;
    assign inst_valid = (state_reg == ST_VALID);
    assign inst       = inst_reg;
    assign inst_pc    = inst_pc_reg;
    assign pc_ena     = pc_ena_comb;
    assign pc_next    = pc_next_comb;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a falling-edge PC register model.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h00400000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        pc_ena;
    logic [31:0] pc_next;

    int tests = 0;
    int failed = 0;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect(redirect),
        .redirect_target(redirect_target),
        .pc_ena(pc_ena), .pc_next(pc_next)
    );

    always #5 clk = ~clk;

    // PC register: loads pc_next on the falling edge of a pc_ena cycle.
    always @(negedge clk or posedge rst) begin
        if (rst) pc <= RESET_PC;
        else if (pc_ena) pc <= pc_next;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},   32'd0);
        chk({tag, "_addr"},  imem_addr,           RESET_PC);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"},  inst,                32'd0);
        chk({tag, "_ipc"},   inst_pc,             RESET_PC);
        chk({tag, "_pcena"}, {31'd0, pc_ena},     32'd0);
        chk({tag, "_pcnxt"}, pc_next,             RESET_PC);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        chk_reset("rst");
        rst = 1'b0;

        // First fetch, ack in first REQ cycle
        tick(); #1;
        chk("f1_req", {31'd0, imem_req}, 32'd1);
        chk("f1_addr", imem_addr, 32'h00400000);
        imem_ack = 1'b1; imem_rdata = 32'h11111111;
        tick();
        imem_ack = 1'b0; inst_ready = 1'b1; #1;
        chk("f1_valid", {31'd0, inst_valid}, 32'd1);
        chk("f1_inst", inst, 32'h11111111);
        chk("f1_ipc", inst_pc, 32'h00400000);
        chk("f1_pcena", {31'd0, pc_ena}, 32'd1);
        chk("f1_pcnext", pc_next, 32'h00400004);
        tick();
        inst_ready = 1'b0; #1;
        chk("f2_pcena0", {31'd0, pc_ena}, 32'd0);
        chk("f2_pcnext_hold", pc_next, 32'h00400004);
        chk("f2_valid0", {31'd0, inst_valid}, 32'd0);

        // Memory wait of 3 cycles: req high for 4 cycles
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin imem_ack = 1'b1; imem_rdata = 32'h22222222; end
            #1;
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h00400004);
            chk("wait_valid0", {31'd0, inst_valid}, 32'd0);
            tick();
        end
        imem_ack = 1'b0;

        // Decode stall for 5 cycles
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_inst", inst, 32'h22222222);
            chk("stall_ipc", inst_pc, 32'h00400004);
            chk("stall_pcena", {31'd0, pc_ena}, 32'd0);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        inst_ready = 1'b1; #1;
        chk("rel_pcena", {31'd0, pc_ena}, 32'd1);
        chk("rel_pcnext", pc_next, 32'h00400008);
        tick();
        inst_ready = 1'b0; #1;
        chk("rel_single", {31'd0, pc_ena}, 32'd0);
        chk("rel_addr", imem_addr, 32'h00400008);

        // Redirect in VALID
        imem_ack = 1'b1; imem_rdata = 32'h33333333;
        tick();
        imem_ack = 1'b0; redirect = 1'b1; redirect_target = 32'h00400103; #1;
        chk("rv_valid", {31'd0, inst_valid}, 32'd1);
        chk("rv_pcena", {31'd0, pc_ena}, 32'd1);
        chk("rv_pcnext", pc_next, 32'h00400100);
        tick();
        redirect = 1'b0; #1;
        chk("rv_valid0", {31'd0, inst_valid}, 32'd0);
        chk("rv_addr", imem_addr, 32'h00400100);
        chk("rv_req", {31'd0, imem_req}, 32'd1);

        // Redirect during outstanding fetch, ack two cycles later
        redirect = 1'b1; redirect_target = 32'h00400200; #1;
        chk("rf_pcena0", {31'd0, pc_ena}, 32'd0);
        tick();
        redirect = 1'b0; #1;
        chk("rf_req1", {31'd0, imem_req}, 32'd1);
        chk("rf_valid1", {31'd0, inst_valid}, 32'd0);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h44444444; #1;
        chk("rf_req2", {31'd0, imem_req}, 32'd1);
        chk("rf_valid2", {31'd0, inst_valid}, 32'd0);
        chk("rf_pcena", {31'd0, pc_ena}, 32'd1);
        chk("rf_pcnext", pc_next, 32'h00400200);
        tick();
        imem_ack = 1'b0; #1;
        chk("rf_valid3", {31'd0, inst_valid}, 32'd0);
        chk("rf_addr", imem_addr, 32'h00400200);

        // Redirect coinciding with ack: data dropped, refetch at target
        imem_ack = 1'b1; imem_rdata = 32'h55555555;
        redirect = 1'b1; redirect_target = 32'hFFFFFFFC; #1;
        chk("ra_pcena", {31'd0, pc_ena}, 32'd1);
        chk("ra_pcnext", pc_next, 32'hFFFFFFFC);
        tick();
        redirect = 1'b0; imem_rdata = 32'h66666666; #1;
        chk("ra_valid0", {31'd0, inst_valid}, 32'd0);
        chk("ra_addr", imem_addr, 32'hFFFFFFFC);

        // Wrap-around
        tick();
        imem_ack = 1'b0; inst_ready = 1'b1; #1;
        chk("wr_inst", inst, 32'h66666666);
        chk("wr_ipc", inst_pc, 32'hFFFFFFFC);
        chk("wr_pcena", {31'd0, pc_ena}, 32'd1);
        chk("wr_pcnext", pc_next, 32'h00000000);
        tick();
        inst_ready = 1'b0; #1;
        chk("wr_addr", imem_addr, 32'h00000000);
        chk("wr_req", {31'd0, imem_req}, 32'd1);

        // Reset mid-fetch takes effect immediately
        rst = 1'b1; #1;
        chk_reset("midrst");
        tick();
        imem_ack = 1'b1; #1;
        chk("midrst_pcena", {31'd0, pc_ena}, 32'd0);
        chk("midrst_valid", {31'd0, inst_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
